// File: rtl/clock_div_twenty_eight_pkg.sv
// Shared clocking constants and helpers for the fixed-ratio divider.
// The divisor check is evaluated at elaboration time by the top level.
package clock_div_twenty_eight_pkg;

   localparam int DIV28_DEFAULT = 28;

   function automatic int cnt_width(input int divisor);
      int w;
      w = $clog2(divisor / 2);
      if (w < 1) w = 1;
      return w;
   endfunction

   function automatic bit div_ok(input int divisor);
      return (divisor >= 2) && (divisor % 2 == 0);
   endfunction

endpackage

// File: rtl/clock_div_twenty_eight_mod_n_counter.sv
// Modulo-N up counter with asynchronous reset and terminal-count flag.
// Out-of-range values collapse to zero on the next edge.
module mod_n_counter
   import clock_div_twenty_eight_pkg::*;
#(
   parameter int N = DIV28_DEFAULT / 2,
   localparam int W = cnt_width(2 * N)
) (
   input  logic         clk_in,
   input  logic         rst,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q = '0;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (int'(cnt_q) >= N - 1) cnt_d = '0;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/clock_div_twenty_eight.sv
// Divide-by-DIVISOR square-wave generator, 50% duty.
// Output comes straight from the toggle flop, so it is glitch-free.
module clock_div_twenty_eight
   import clock_div_twenty_eight_pkg::*;
#(
   parameter int DIVISOR = DIV28_DEFAULT
) (
   input  logic clk_in,
   input  logic rst,
   output logic clk_div_28
);

   localparam int HALF = DIVISOR / 2;
   localparam int CW   = cnt_width(DIVISOR);

   if (!div_ok(DIVISOR)) begin : g_bad_divisor
      $error("DIVISOR must be even and >= 2");
   end

   logic [CW-1:0] cnt;
   logic          tc;

   mod_n_counter #(
      .N (HALF)
   ) u_cnt (
      .clk_in (clk_in),
      .rst    (rst),
      .cnt    (cnt),
      .tc     (tc)
   );

   logic clk_q = 1'b0;
   logic clk_d;

   always_comb begin
      clk_d = clk_q;
      if (tc) clk_d = ~clk_q;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) clk_q <= 1'b0;
      else     clk_q <= clk_d;
   end

   assign clk_div_28 = clk_q;

   a_cnt_range: assert property (
      @(posedge clk_in) disable iff (rst) int'(cnt) < HALF
   );

endmodule

// File: tb/tb_clock_div_twenty_eight.sv
// Directed bench for clock_div_twenty_eight at DIVISOR 28, 4 and 2.
// Expected levels come from edge counting: level = (edge / half) mod 2.
module tb_clock_div_twenty_eight;

   logic clk_in = 1'b0;
   logic rst    = 1'b0;
   logic o28, o4, o2;

   int n_run  = 0;
   int n_fail = 0;

   always #10 clk_in = ~clk_in;

   clock_div_twenty_eight dut28 (
      .clk_in     (clk_in),
      .rst        (rst),
      .clk_div_28 (o28)
   );

   clock_div_twenty_eight #(.DIVISOR(4)) dut4 (
      .clk_in     (clk_in),
      .rst        (rst),
      .clk_div_28 (o4)
   );

   clock_div_twenty_eight #(.DIVISOR(2)) dut2 (
      .clk_in     (clk_in),
      .rst        (rst),
      .clk_div_28 (o2)
   );

   function automatic logic [31:0] lvl(input int e, input int half);
      return 32'((e / half) % 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int e);
      chk({tag, "_o28"}, 32'(o28), lvl(e, 14));
      chk({tag, "_o4"},  32'(o4),  lvl(e, 2));
      chk({tag, "_o2"},  32'(o2),  lvl(e, 1));
      chk({tag, "_cnt"}, 32'(dut28.u_cnt.cnt_q), 32'(e % 14));
   endtask

   task automatic run_edges(input string tag, input int n);
      for (int e = 1; e <= n; e++) begin
         @(posedge clk_in);
         #1;
         chk_all(tag, e);
      end
   endtask

   initial begin
      // Power-up with rst never asserted: defined zero, first rise at edge 14
      #1;
      chk_all("pwrup0", 0);
      run_edges("pwrup", 20);

      // 3 ns async pulse at edge 20 + 5 ns while o28 is high
      #4;
      rst = 1'b1;
      #1;
      chk_all("pulse", 0);
      #2;
      rst = 1'b0;
      run_edges("after_pulse", 28);

      // Held reset across 5 clock edges
      @(negedge clk_in);
      rst = 1'b1;
      #1;
      chk_all("rst_async", 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_in);
         #1;
         chk_all("rst_hold", 0);
      end
      @(negedge clk_in);
      rst = 1'b0;

      // Ten output periods of the /28 output
      run_edges("steady", 280);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clock_div_twenty_eight.md
# clock_div_twenty_eight

Fixed-ratio clock divider producing a 50%-duty square wave at 1/28 of the input clock frequency. It sits at the clock-generation layer and feeds slower downstream logic, such as display refresh or debouncing, from the board clock. The output is driven directly from a flip-flop, so it is glitch-free. Its period is exactly 28 input cycles: 14 high, 14 low.

## Interface
- DIVISOR, default 28: division ratio; must be even and ≥ 2; non-even or < 2 values are a compile-time error.
- clk_in  input  1  input clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clock clk_in.
- clk_div_28  output  1  divided clock, registered, frequency clk_in/DIVISOR, 50% duty.

## Operation
- Internal half-period counter `cnt`.
  - Width: ceil(log2(DIVISOR/2)), minimum 1 bit.
  - Range: 0 .. DIVISOR/2−1, which is 0..13 for the default.
- On each clk_in rising edge with rst low:
  - If cnt == DIVISOR/2−1: cnt ← 0 and clk_div_28 ← ~clk_div_28.
  - Else: cnt ← cnt+1 and clk_div_28 holds.
- While rst is high:
  - cnt = 0 and clk_div_28 = 0, forced immediately without waiting for a clock edge.
  - Clock edges are ignored while rst is high.
- Power-up: cnt and clk_div_28 carry initial value 0, so the output is defined (0, never X) even if rst is never asserted.
- Counter wrap: the terminal count 13 is followed by 0; no other values are reachable. If an illegal value appears, for example after a glitch, the next edge forces cnt to 0.
- No enable and no phase adjustment. The output is never combinationally derived from cnt.

## Timing
- Reset value of clk_div_28 is 0; reset value of cnt is 0.
- Edges are counted from the first clk_in rising edge after rst deasserts (edge 1) or after power-up.
  - Edge 14: clk_div_28 rises.
  - Edge 28: clk_div_28 falls.
  - Edge 42: clk_div_28 rises; the pattern repeats every 28 edges.
- Output transitions occur one clk-to-q delay after the triggering clk_in rising edge.
- Reset asserted mid-operation, high or low phase: clk_div_28 goes to 0 asynchronously and the count restarts. The first rise is at edge 14 after release.
- rst deasserting coincident with a clk_in rising edge: that edge is not counted; counting starts at the next edge.
- Latency from reset release to the first output edge is 14 input cycles.

## Structure
- Shared clocking package holds:
  - Constant DIV28_DEFAULT = 28.
  - Function returning the counter width for a given divisor.
  - Elaboration check that the divisor is even and ≥ 2.
- One natural sub-module, `mod_n_counter`:
  - Parameter N; asynchronous reset.
  - Outputs the count and a terminal-count pulse `tc` (cnt == N−1).
  - The top-level instantiates it with N = DIVISOR/2 and toggles a single output flop on `tc`.
- The top level contains only the toggle flop, the reset handling and the parameter checks.

## Test plan
- Reset behaviour: hold rst=1 for 5 clk_in cycles of 20 ns period. Required: clk_div_28 = 0 throughout and cnt = 0.
- First edge after reset: release rst, then count rising edges. Required: clk_div_28 = 0 through edge 13, then 1 from edge 14.
- Steady state over 10 output periods:
  - Each high phase is exactly 14 clk_in cycles (280 ns) and each low phase exactly 14 cycles (280 ns).
  - Output period is 560 ns.
- Asynchronous reset mid-high-phase: pulse rst at edge 20 + 5 ns for 3 ns, between clock edges. Required: clk_div_28 drops to 0 within the pulse with no clock edge, and the next rise is at edge 14 after release.
- No reset ever asserted (rst tied 0 from time 0): clk_div_28 is 0, not X, from time 0 and rises at edge 14.
- Parameter sweep with DIVISOR = 2, 4 and 28: output period equals DIVISOR cycles with 50% duty. For DIVISOR = 2, the output toggles on every clk_in edge.
